// File: rtl/native_wb_bridge_if.sv
// rtl/native_wb_bridge_if.sv - native memory port and Wishbone classic bus interfaces
//
// native_mem_if : core-side valid/ready port.
//   master (core)   drives valid, instr, addr, wdata, wstrb; receives ready, rdata.
//   slave  (bridge) receives the request; drives ready, rdata.
// wb_bus_if     : Wishbone classic single-transfer bus.
//   master (bridge) drives cyc, stb, we, sel, addr, data_out; receives data_in, ack.
//   slave  (memory) receives the cycle; drives data_in, ack.

interface native_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_W = DATA_WIDTH / 8;

    logic                  valid;
    logic                  instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SEL_W-1:0]      wstrb;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

interface wb_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_W = DATA_WIDTH / 8;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ack;

    modport master (output cyc, stb, we, sel, addr, data_out, input data_in, ack);
    modport slave  (input cyc, stb, we, sel, addr, data_out, output data_in, ack);
endinterface

// File: rtl/native_wb_bridge.sv
// rtl/native_wb_bridge.sv - registered native valid/ready to Wishbone classic bridge
//
// One outstanding transaction at a time: IDLE -> BUS -> RESP -> IDLE.
// Hung bus cycles are terminated after TIMEOUT_CYCLES (0 = never) with
// ERR_WORD returned and the sticky bus_err flag set.
//
// Ports:
//   clk      : core clock
//   rst      : asynchronous active-high reset
//   mem      : native memory port (slave side)
//   core     : Wishbone master port (all traffic, or fetches when split)
//   data_mem : Wishbone master port for data traffic (SECOND_MEMORY_EN only)
//   bus_err  : sticky timeout flag
//
// Build option: define SECOND_MEMORY_EN to route mem.instr = 0 traffic to data_mem.

module native_wb_bridge #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            rst,
    native_mem_if.slave     mem,
    wb_bus_if.master        core,
`ifdef SECOND_MEMORY_EN
    wb_bus_if.master        data_mem,
`endif
    output logic            bus_err
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Expiry is detected on the edge where the counter would reach TIMEOUT_CYCLES,
    // so cyc stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_WORD);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  core_cyc_q;
    logic                  we_q;
    logic [SEL_W-1:0]      sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  bus_ack;
    logic [DATA_WIDTH-1:0] bus_data_in;

`ifdef SECOND_MEMORY_EN
    logic dm_cyc_q;
    logic use_dm_q;

    // Only the port that owns the current cycle is listened to.
    assign bus_ack     = use_dm_q ? data_mem.ack     : core.ack;
    assign bus_data_in = use_dm_q ? data_mem.data_in : core.data_in;

    assign data_mem.cyc      = dm_cyc_q;
    assign data_mem.stb      = dm_cyc_q;
    assign data_mem.we       = we_q;
    assign data_mem.sel      = sel_q;
    assign data_mem.addr     = addr_q;
    assign data_mem.data_out = wdata_q;
`else
    logic unused_instr;

    assign unused_instr = mem.instr;
    assign bus_ack      = core.ack;
    assign bus_data_in  = core.data_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            core_cyc_q <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef SECOND_MEMORY_EN
            dm_cyc_q   <= 1'b0;
            use_dm_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem.valid) begin
                        addr_q  <= mem.addr;
                        wdata_q <= mem.wdata;
                        we_q    <= |mem.wstrb;
                        sel_q   <= (|mem.wstrb) ? mem.wstrb : '1;
                        cnt     <= '0;
                        state   <= S_BUS;
`ifdef SECOND_MEMORY_EN
                        use_dm_q   <= ~mem.instr;
                        core_cyc_q <= mem.instr;
                        dm_cyc_q   <= ~mem.instr;
`else
                        core_cyc_q <= 1'b1;
`endif
                    end
                end
                S_BUS: begin
                    // ack takes priority over a timeout expiring on the same edge
                    if (bus_ack) begin
                        if (!we_q) begin
                            rdata_q <= bus_data_in;
                        end
                        core_cyc_q <= 1'b0;
`ifdef SECOND_MEMORY_EN
                        dm_cyc_q   <= 1'b0;
`endif
                        ready_q    <= 1'b1;
                        state      <= S_RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                        core_cyc_q <= 1'b0;
`ifdef SECOND_MEMORY_EN
                        dm_cyc_q   <= 1'b0;
`endif
                        rdata_q    <= ERR_DATA;
                        err_q      <= 1'b1;
                        ready_q    <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign core.cyc      = core_cyc_q;
    assign core.stb      = core_cyc_q;
    assign core.we       = we_q;
    assign core.sel      = sel_q;
    assign core.addr     = addr_q;
    assign core.data_out = wdata_q;

    assign mem.ready = ready_q;
    assign mem.rdata = rdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_native_wb_bridge.sv
// tb/tb_native_wb_bridge.sv - self-checking bench for native_wb_bridge

module tb_native_wb_bridge;
    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk_core = 1'b0;
    logic rst_core = 1'b1;
    logic bus_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;

    native_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();
    wb_bus_if     #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) core_bus ();
    wb_bus_if     #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dm_bus ();

    always #5 clk_core = ~clk_core;

    native_wb_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T),
        .ERR_WORD(ERR)
    ) dut (
        .clk(clk_core),
        .rst(rst_core),
        .mem(mem_bus),
        .core(core_bus),
`ifdef SECOND_MEMORY_EN
        .data_mem(dm_bus),
`endif
        .bus_err(bus_err)
    );

    // One transaction. ack_at = edge index at which the slave acks (0 = never).
    task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input bit instr, input int ack_at,
                           input logic [31:0] ad);
        bit          timed_out;
        int          exp_cyc;
        bit          use_dm;
        logic        exp_we;
        logic [3:0]  exp_sel;
        int          cyc_cnt = 0;
        int          ready_first = 0;
        int          ready_cnt = 0;
        int          attr_bad = 0;
        int          other_bad = 0;
        logic [31:0] rd_seen = '0;
        logic        act_cyc, act_stb, act_we, oth_cyc;
        logic [3:0]  act_sel;
        logic [31:0] act_addr, act_dout;

        timed_out = (ack_at == 0) || (ack_at > T);
        exp_cyc   = timed_out ? T : ack_at;
        exp_we    = (ws != 4'h0);
        exp_sel   = (ws != 4'h0) ? ws : 4'hF;
`ifdef SECOND_MEMORY_EN
        use_dm = !instr;
`else
        use_dm = 1'b0;
`endif
        if (timed_out) begin
            exp_rdata = ERR;
            exp_err   = 1'b1;
        end else if (ws == 4'h0) begin
            exp_rdata = ad;
        end

        @(negedge clk_core);
        mem_bus.valid = 1'b1;
        mem_bus.instr = instr;
        mem_bus.addr  = a;
        mem_bus.wdata = wd;
        mem_bus.wstrb = ws;
        @(posedge clk_core);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk_core);
            if (use_dm) begin
                act_cyc = dm_bus.cyc;   act_stb = dm_bus.stb;  act_we = dm_bus.we;
                act_sel = dm_bus.sel;   act_addr = dm_bus.addr; act_dout = dm_bus.data_out;
                oth_cyc = core_bus.cyc | core_bus.stb;
            end else begin
                act_cyc = core_bus.cyc; act_stb = core_bus.stb; act_we = core_bus.we;
                act_sel = core_bus.sel; act_addr = core_bus.addr; act_dout = core_bus.data_out;
`ifdef SECOND_MEMORY_EN
                oth_cyc = dm_bus.cyc | dm_bus.stb;
`else
                oth_cyc = 1'b0;
`endif
            end
            if (act_cyc === 1'b1) begin
                cyc_cnt++;
                if (act_stb !== 1'b1 || act_we !== exp_we || act_sel !== exp_sel ||
                    act_addr !== a || act_dout !== wd)
                    attr_bad++;
            end
            if (oth_cyc !== 1'b0) other_bad++;
            if (mem_bus.ready === 1'b1) begin
                ready_cnt++;
                if (ready_first == 0) begin
                    ready_first   = k;
                    rd_seen       = mem_bus.rdata;
                    mem_bus.valid = 1'b0;
                end
            end
            if (ready_first != 0 && k == ready_first + 1) break;
            core_bus.ack = 1'b0;  core_bus.data_in = $urandom;
            dm_bus.ack   = 1'b0;  dm_bus.data_in   = $urandom;
            if (k == ack_at) begin
                if (use_dm) begin dm_bus.ack = 1'b1; dm_bus.data_in = ad; end
                else begin core_bus.ack = 1'b1; core_bus.data_in = ad; end
            end
`ifdef SECOND_MEMORY_EN
            // spurious acks on the port that does not own the cycle
            if (use_dm) core_bus.ack = 1'($urandom_range(0, 1));
            else        dm_bus.ack   = 1'($urandom_range(0, 1));
`endif
            @(posedge clk_core);
        end
        mem_bus.valid = 1'b0;
        core_bus.ack  = 1'b0;
        dm_bus.ack    = 1'b0;

        checks++;
        if (cyc_cnt != exp_cyc) begin
            errors++; $display("FAIL %s cyc_cycles: got %0d expected %0d", name, cyc_cnt, exp_cyc);
        end
        checks++;
        if (ready_first != exp_cyc + 1) begin
            errors++; $display("FAIL %s ready_latency: got %0d expected %0d", name, ready_first, exp_cyc + 1);
        end
        checks++;
        if (ready_cnt != 1) begin
            errors++; $display("FAIL %s ready_pulses: got %0d expected 1", name, ready_cnt);
        end
        checks++;
        if (attr_bad != 0) begin
            errors++; $display("FAIL %s bus_attrs: got %0d bad samples expected 0", name, attr_bad);
        end
`ifdef SECOND_MEMORY_EN
        checks++;
        if (other_bad != 0) begin
            errors++; $display("FAIL %s idle_port_active: got %0d samples expected 0", name, other_bad);
        end
`endif
        checks++;
        if (rd_seen !== exp_rdata) begin
            errors++; $display("FAIL %s rdata: got %h expected %h", name, rd_seen, exp_rdata);
        end
        checks++;
        if (bus_err !== exp_err) begin
            errors++; $display("FAIL %s bus_err: got %b expected %b", name, bus_err, exp_err);
        end
    endtask

    task automatic test_reset();
        mem_bus.valid = 1'b0; mem_bus.instr = 1'b1; mem_bus.addr = '0;
        mem_bus.wdata = '0;   mem_bus.wstrb = '0;
        core_bus.ack = 1'b0;  core_bus.data_in = '0;
        dm_bus.ack = 1'b0;    dm_bus.data_in = '0;
        rst_core = 1'b1;
        repeat (3) @(negedge clk_core);
        checks++;
        if ({core_bus.cyc, core_bus.stb, core_bus.we, mem_bus.ready, bus_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000",
                {core_bus.cyc, core_bus.stb, core_bus.we, mem_bus.ready, bus_err});
        end
        checks++;
        if (core_bus.sel !== 4'h0 || core_bus.addr !== 32'h0 || core_bus.data_out !== 32'h0) begin
            errors++; $display("FAIL reset_bus: got sel %h addr %h dout %h expected zeros",
                core_bus.sel, core_bus.addr, core_bus.data_out);
        end
        checks++;
        if (mem_bus.rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", mem_bus.rdata);
        end
        rst_core = 1'b0;
    endtask

    task automatic test_read();
        run_txn("read", 32'h100, 32'h0, 4'h0, 1'b1, 3, 32'h1234_5678);
    endtask

    task automatic test_byte_write();
        run_txn("byte_write", 32'h202, 32'h00AB_0000, 4'b0100, 1'b1, 2, 32'hFFFF_FFFF);
    endtask

    task automatic test_idle_ack();
        int bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_core);
            if (mem_bus.ready !== 1'b0 || core_bus.cyc !== 1'b0) bad++;
            core_bus.ack = 1'($urandom_range(0, 1)); core_bus.data_in = $urandom;
            dm_bus.ack   = 1'($urandom_range(0, 1)); dm_bus.data_in   = $urandom;
        end
        @(negedge clk_core);
        core_bus.ack = 1'b0; dm_bus.ack = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL idle_ack_activity: got %0d bad samples expected 0", bad);
        end
        checks++;
        if (mem_bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL idle_ack_rdata: got %h expected %h", mem_bus.rdata, exp_rdata);
        end
    endtask

    task automatic test_collision();
        run_txn("collision", 32'h300, 32'h0, 4'h0, 1'b1, T, 32'h0000_0055);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 32'h400, 32'h0, 4'h0, 1'b1, 0, 32'h0);
        run_txn("after_timeout", 32'h404, 32'h0, 4'h0, 1'b1, 1, 32'hCAFE_0001);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [3];
        logic [31:0] rd [3];
        logic [12:0] cyc_v = '0, rdy_v = '0, exp_cyc_v = '0, exp_rdy_v = '0;
        int n_done = 0, n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            rd[i] = '0;
            exp_cyc_v[1 + 3 * i] = 1'b1;
            exp_rdy_v[2 + 3 * i] = 1'b1;
        end
        @(negedge clk_core);
        mem_bus.valid = 1'b1; mem_bus.instr = 1'b1; mem_bus.wstrb = 4'h0;
        mem_bus.addr = 32'h1000;
        @(posedge clk_core);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_core);
            cyc_v[k] = core_bus.cyc;
            rdy_v[k] = mem_bus.ready;
            if (mem_bus.ready === 1'b1 && n_done < 3) begin
                rd[n_done] = mem_bus.rdata;
                n_done++;
                if (n_done < 3) mem_bus.addr = 32'h1000 + 32'(4 * n_done);
                else mem_bus.valid = 1'b0;
            end
            core_bus.ack = 1'b0;
            if (core_bus.cyc === 1'b1 && n_ack < 3) begin
                core_bus.ack = 1'b1; core_bus.data_in = d[n_ack]; n_ack++;
            end
            @(posedge clk_core);
        end
        @(negedge clk_core);
        core_bus.ack = 1'b0;
        mem_bus.valid = 1'b0;
        checks++;
        if (cyc_v !== exp_cyc_v) begin
            errors++; $display("FAIL b2b_cyc_pattern: got %b expected %b", cyc_v, exp_cyc_v);
        end
        checks++;
        if (rdy_v !== exp_rdy_v) begin
            errors++; $display("FAIL b2b_ready_pattern: got %b expected %b", rdy_v, exp_rdy_v);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd[i] !== d[i]) begin
                errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, rd[i], d[i]);
            end
        end
        exp_rdata = d[2];
    endtask

    task automatic test_random();
        logic [3:0]  ws;
        int          ack_at;
        for (int i = 0; i < 20; i++) begin
            ws     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ack_at = $urandom_range(1, T + 2);
            run_txn($sformatf("random%0d", i), $urandom, $urandom, ws,
                    1'($urandom_range(0, 1)), ack_at, $urandom);
        end
    endtask

    task automatic test_reset_mid();
        logic was_busy;
        @(negedge clk_core);
        mem_bus.valid = 1'b1; mem_bus.instr = 1'b1; mem_bus.wstrb = 4'h0;
        mem_bus.addr = 32'h500;
        @(posedge clk_core);
        @(negedge clk_core);
        was_busy = core_bus.cyc;
        #2 rst_core = 1'b1;
        #1;
        checks++;
        if (was_busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_busy: got %b expected 1", was_busy);
        end
        checks++;
        if ({core_bus.cyc, core_bus.stb, mem_bus.ready} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_async: got %b expected 000",
                {core_bus.cyc, core_bus.stb, mem_bus.ready});
        end
        exp_rdata = '0;
        exp_err   = 1'b0;
        checks++;
        if (bus_err !== exp_err || mem_bus.rdata !== exp_rdata) begin
            errors++; $display("FAIL rst_mid_regs: got err %b rdata %h expected 0 0", bus_err, mem_bus.rdata);
        end
        mem_bus.valid = 1'b0;
        @(negedge clk_core);
        rst_core = 1'b0;
        core_bus.ack = 1'b1; core_bus.data_in = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk_core);
        core_bus.ack = 1'b0;
        checks++;
        if (mem_bus.ready !== 1'b0 || mem_bus.rdata !== exp_rdata || core_bus.cyc !== 1'b0) begin
            errors++; $display("FAIL rst_mid_late_ack: got ready %b rdata %h cyc %b expected 0 %h 0",
                mem_bus.ready, mem_bus.rdata, core_bus.cyc, exp_rdata);
        end
        run_txn("after_reset", 32'h504, 32'h0, 4'h0, 1'b1, 2, 32'h600D_F00D);
    endtask

`ifdef SECOND_MEMORY_EN
    task automatic test_split_ports();
        run_txn("split_fetch", 32'h0, 32'h0, 4'h0, 1'b1, 2, 32'h0000_0013);
        run_txn("split_load", 32'h8000, 32'h0, 4'h0, 1'b0, 3, 32'h8765_4321);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_idle_ack();
        test_collision();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SECOND_MEMORY_EN
        test_split_ports();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
